hex7seg_scan: RTL and testbench



---
 rtl/hex7seg_scan.sv | 153 +++++++++++++++
 tb/tb_hex7seg_scan.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/hex7seg_scan.sv
// Time-multiplexed hex 7-segment driver: shadow/display double buffer updated on frame
// boundaries, prescaled digit scan with a blank interval at the head of every slot.
module hex7seg_scan #(
    parameter int DIGITS        = 4,
    parameter int DIV_WIDTH     = 10,
    parameter int BLANK_CYCLES  = 4,
    parameter int EN_ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dots,
    input  logic                  load,
    input  logic                  inv,
    input  logic                  blank_lz,
    output logic [7:0]            segments,
    output logic [DIGITS-1:0]     digit_en,
    output logic                  frame
);

    localparam int                  IDX_W      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DIV_WIDTH-1:0] DIV_ZERO   = {DIV_WIDTH{1'b0}};
    localparam logic [DIV_WIDTH-1:0] DIV_LAST   = {DIV_WIDTH{1'b1}};
    localparam logic [DIV_WIDTH-1:0] BLANK_LAST = DIV_WIDTH'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0]     IDX_ZERO   = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0]     IDX_LAST   = IDX_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0]    EN_OFF     = {DIGITS{(EN_ACTIVE_LOW != 0)}};

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    function automatic logic [6:0] glyph(input logic [3:0] nib);
        case (nib)
            4'h0:    glyph = 7'h3F;
            4'h1:    glyph = 7'h06;
            4'h2:    glyph = 7'h5B;
            4'h3:    glyph = 7'h4F;
            4'h4:    glyph = 7'h66;
            4'h5:    glyph = 7'h6D;
            4'h6:    glyph = 7'h7D;
            4'h7:    glyph = 7'h07;
            4'h8:    glyph = 7'h7F;
            4'h9:    glyph = 7'h6F;
            4'hA:    glyph = 7'h77;
            4'hB:    glyph = 7'h7C;
            4'hC:    glyph = 7'h39;
            4'hD:    glyph = 7'h5E;
            4'hE:    glyph = 7'h79;
            4'hF:    glyph = 7'h71;
            default: glyph = 7'h00;
        endcase
    endfunction

    logic [4*DIGITS-1:0] shadow_value_r;
    logic [DIGITS-1:0]   shadow_dots_r;
    logic                pending_r;
    logic [4*DIGITS-1:0] disp_value_r;
    logic [DIGITS-1:0]   disp_dots_r;
    logic [DIV_WIDTH-1:0] div_cnt_r;
    logic [IDX_W-1:0]    idx_r;
    state_t              state_r;

    logic                slot_end_s;
    logic                boundary_s;
    logic [3:0]          cur_nib_s;
    logic                cur_dot_s;
    logic                upper_zero_s;
    logic                suppress_s;
    logic [DIGITS-1:0]   onehot_s;
    logic [7:0]          show_seg_s;

    assign slot_end_s = (div_cnt_r == DIV_LAST);
    assign boundary_s = slot_end_s && (idx_r == IDX_LAST);

    // Glyph and digit-select for the digit currently being scanned
    always_comb begin
        cur_nib_s    = disp_value_r[{idx_r, 2'b00} +: 4];
        cur_dot_s    = disp_dots_r[idx_r];
        upper_zero_s = 1'b1;
        onehot_s     = {DIGITS{1'b0}};
        for (int i = 0; i < DIGITS; i++) begin
            // only nibbles at or above the scanned digit decide suppression
            upper_zero_s = upper_zero_s &
                           ((IDX_W'(i) < idx_r) | (disp_value_r[4*i +: 4] == 4'h0));
            onehot_s[i]  = (IDX_W'(i) == idx_r);
        end
        suppress_s = blank_lz && upper_zero_s && (idx_r != IDX_ZERO);
        show_seg_s = {cur_dot_s, (suppress_s ? 7'h00 : glyph(cur_nib_s))} ^ {8{inv}};
    end

    // Shadow capture and frame-synchronous transfer into the display registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_value_r <= {(4*DIGITS){1'b0}};
            shadow_dots_r  <= {DIGITS{1'b0}};
            pending_r      <= 1'b0;
            disp_value_r   <= {(4*DIGITS){1'b0}};
            disp_dots_r    <= {DIGITS{1'b0}};
        end else begin
            if (load) begin
                shadow_value_r <= value;
                shadow_dots_r  <= dots;
            end
            if (boundary_s) begin
                if (load) begin
                    disp_value_r <= value;
                    disp_dots_r  <= dots;
                    pending_r    <= 1'b0;
                end else if (pending_r) begin
                    disp_value_r <= shadow_value_r;
                    disp_dots_r  <= shadow_dots_r;
                    pending_r    <= 1'b0;
                end
            end else if (load) begin
                pending_r <= 1'b1;
            end
        end
    end

    // Slot FSM, prescaler, digit index and registered pin outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_r <= DIV_ZERO;
            idx_r     <= IDX_ZERO;
            state_r   <= ST_BLANK;
            segments  <= 8'h00;
            digit_en  <= EN_OFF;
            frame     <= 1'b0;
        end else begin
            div_cnt_r <= div_cnt_r + 1'b1;
            frame     <= (div_cnt_r == DIV_ZERO) && (idx_r == IDX_ZERO);
            if (slot_end_s) begin
                state_r <= ST_BLANK;
                idx_r   <= (idx_r == IDX_LAST) ? IDX_ZERO : idx_r + 1'b1;
            end else if (div_cnt_r == BLANK_LAST) begin
                state_r <= ST_SHOW;
            end
            case (state_r)
                ST_SHOW: begin
                    segments <= show_seg_s;
                    digit_en <= onehot_s ^ EN_OFF;
                end
                default: begin
                    segments <= {8{inv}};
                    digit_en <= EN_OFF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hex7seg_scan.sv
// Scoreboard bench for hex7seg_scan: stimulus queues the expected digits of a frame,
// a monitor pops one entry at the first clock of every shown digit.
module tb_hex7seg_scan;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] value;
    logic [3:0]  dots;
    logic        load;
    logic        inv;
    logic        blank_lz;
    logic [7:0]  segments;
    logic [3:0]  digit_en;
    logic        frame;
    logic [7:0]  segments_low;
    logic [3:0]  digit_en_low;
    logic        frame_low;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] en;
        logic [7:0] seg;
        logic [7:0] blank;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    hex7seg_scan #(.DIGITS(4), .DIV_WIDTH(3), .BLANK_CYCLES(2), .EN_ACTIVE_LOW(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .value(value), .dots(dots), .load(load), .inv(inv),
        .blank_lz(blank_lz), .segments(segments), .digit_en(digit_en), .frame(frame)
    );

    hex7seg_scan #(.DIGITS(4), .DIV_WIDTH(3), .BLANK_CYCLES(2), .EN_ACTIVE_LOW(1)) u_dut_low (
        .clk(clk), .rst_n(rst_n), .value(value), .dots(dots), .load(load), .inv(inv),
        .blank_lz(blank_lz), .segments(segments_low), .digit_en(digit_en_low), .frame(frame_low)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_frame(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2,
                              input logic [7:0] s3, input logic [7:0] blank);
        sb_q.push_back('{en: 4'b0001, seg: s0, blank: blank});
        sb_q.push_back('{en: 4'b0010, seg: s1, blank: blank});
        sb_q.push_back('{en: 4'b0100, seg: s2, blank: blank});
        sb_q.push_back('{en: 4'b1000, seg: s3, blank: blank});
    endtask

    task automatic wait_frame(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame && n < 80);
        if (!frame) begin
            checks++;
            errors++;
            $display("FAIL wait_frame: no frame pulse within %0d clocks", n);
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        value = v;
        dots  = d;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Monitor: compares each shown digit, slot timing and frame period
    initial begin
        int   cyc = 0;
        int   last_frame = 0;
        bit   have_last = 1'b0;
        int   blank_run = 0;
        int   show_run = 0;
        bit   in_show = 1'b0;
        bit   checked_run = 1'b0;
        logic [7:0] prev_seg = 8'h00;
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                have_last = 1'b0;
                blank_run = 0;
                show_run  = 0;
                in_show   = 1'b0;
            end else begin
                if (frame) begin
                    check("frame_during_blank", {28'h0, digit_en}, 32'h0);
                    if (have_last) check("frame_period", cyc - last_frame, 32);
                    last_frame = cyc;
                    have_last  = 1'b1;
                    blank_run  = 0;
                end
                if (digit_en != 4'b0000) begin
                    if (!in_show) begin
                        if (sb_q.size() > 0) begin
                            e = sb_q.pop_front();
                            check("digit_en", {28'h0, digit_en}, {28'h0, e.en});
                            check("segments", {24'h0, segments}, {24'h0, e.seg});
                            check("digit_en_low", {28'h0, digit_en_low}, {28'h0, ~e.en});
                            check("blank_segments", {24'h0, prev_seg}, {24'h0, e.blank});
                            check("blank_length", blank_run, 2);
                            checked_run = 1'b1;
                        end else begin
                            checked_run = 1'b0;
                        end
                        in_show  = 1'b1;
                        show_run = 0;
                    end
                    show_run++;
                end else begin
                    if (in_show) begin
                        if (checked_run) check("show_length", show_run, 6);
                        in_show   = 1'b0;
                        blank_run = 0;
                    end
                    blank_run++;
                end
                prev_seg = segments;
            end
        end
    end

    // Stimulus: directed frames with hand-computed glyphs
    initial begin
        int n;
        rst_n    = 1'b0;
        value    = 16'h0000;
        dots     = 4'b0000;
        load     = 1'b0;
        inv      = 1'b0;
        blank_lz = 1'b0;
        idle(3);
        check("reset_segments", {24'h0, segments}, 32'h00);
        check("reset_digit_en", {28'h0, digit_en}, 32'h0);
        check("reset_digit_en_low", {28'h0, digit_en_low}, 32'hF);
        check("reset_frame", {31'h0, frame}, 32'h0);
        rst_n = 1'b1;

        // F0: empty display shows 0 on every digit; queue 1234
        wait_frame(n);
        push_frame(8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h00);
        do_load(16'h1234, 4'b0000);

        // F1: 1234, load ABCD mid-frame must not tear
        wait_frame(n);
        push_frame(8'h66, 8'h4F, 8'h5B, 8'h06, 8'h00);
        idle(10);
        do_load(16'hABCD, 4'b0000);

        // F2: ABCD; two loads, last wins
        wait_frame(n);
        push_frame(8'h5E, 8'h39, 8'h7C, 8'h77, 8'h00);
        idle(4);
        do_load(16'h1111, 4'b0000);
        idle(6);
        do_load(16'h5678, 4'b0000);

        // F3: 5678; queue 0005 with dot on digit 2
        wait_frame(n);
        push_frame(8'h7F, 8'h07, 8'h7D, 8'h6D, 8'h00);
        do_load(16'h0005, 4'b0100);

        // F4: leading-zero suppression on
        wait_frame(n);
        blank_lz = 1'b1;
        push_frame(8'h6D, 8'h00, 8'h80, 8'h00, 8'h00);

        // F5: suppression off; queue 0008
        wait_frame(n);
        blank_lz = 1'b0;
        push_frame(8'h6D, 8'h3F, 8'hBF, 8'h3F, 8'h00);
        do_load(16'h0008, 4'b0000);

        // F6: inverted segments
        wait_frame(n);
        inv = 1'b1;
        push_frame(8'h80, 8'hC0, 8'hC0, 8'hC0, 8'hFF);

        // F7: normal polarity; load lands exactly on the frame-boundary clock
        wait_frame(n);
        inv = 1'b0;
        push_frame(8'h7F, 8'h3F, 8'h3F, 8'h3F, 8'h00);
        idle(30);
        do_load(16'h2A7E, 4'b0000);

        // F8, F9: boundary-loaded value shows at once and stays
        wait_frame(n);
        check("boundary_frame_on_time", n, 1);
        push_frame(8'h79, 8'h07, 8'h77, 8'h5B, 8'h00);
        wait_frame(n);
        push_frame(8'h79, 8'h07, 8'h77, 8'h5B, 8'h00);

        // F10: pending load then asynchronous reset in slot 2
        wait_frame(n);
        idle(4);
        do_load(16'h7777, 4'b0000);
        idle(15);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_segments", {24'h0, segments}, 32'h00);
        check("midreset_digit_en", {28'h0, digit_en}, 32'h0);
        check("midreset_digit_en_low", {28'h0, digit_en_low}, 32'hF);
        check("midreset_frame", {31'h0, frame}, 32'h0);
        idle(2);
        rst_n = 1'b1;
        wait_frame(n);
        check("restart_first_frame", n, 1);
        push_frame(8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h00);
        wait_frame(n);
        check("restart_frame_period", n, 32);
        wait_frame(n);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
